// File: rtl/uart_cts_transmitter_pkg.sv
// Shared UART transmitter definitions: default baud divisor, frame constants, FSM encoding.
// Latency: none (types and constants only).
// Backpressure: n/a.
package uart_cts_transmitter_pkg;

    localparam int       DEFAULT_CLOCKS_PER_BAUD = 8;
    localparam int       UART_DATA_BITS          = 8;
    localparam logic     LINE_IDLE               = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the valid/ready source and the serial framer; registered full/empty.
// Latency: a push at edge N shows as non-empty right after edge N; read data is combinational from the head.
// Backpressure: push ignored while full; simultaneous push and pop keep the count unchanged.
module uart_tx_fifo #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_vld && !full_q;
    assign do_pop  = pop && !empty_q;
    assign rd_dat  = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

    // Next pointers, occupancy and flags; flags are registered off the next count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CntW'(Depth));
        empty_d = (cnt_d == '0);
    end

    // Storage array carries no reset; only control state is cleared.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous active-low reset; reset wins over any push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

endmodule

// File: rtl/uart_cts_transmitter.sv
// UART transmitter gated by the peer's active-low clear-to-send; UART_TX_PARITY_EN adds an even parity bit.
// Latency: byte pushed at edge N into an idle, cleared path drives the start bit from edge N+2.
// Backpressure: tx_byte_ready drops when the FIFO is full or in reset; CTS only gates frame starts.
module uart_cts_transmitter
    import uart_cts_transmitter_pkg::*;
#(
    parameter int ClocksPerBaud = DEFAULT_CLOCKS_PER_BAUD,
    parameter int FifoDepth     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_byte_valid,
    output logic       tx_byte_ready,
    input  logic       clear_to_send_n,
    output logic       tx_out,
    output logic       tx_busy
);

    localparam int CntW = (ClocksPerBaud > 1) ? $clog2(ClocksPerBaud) : 1;
    localparam int BitW = $clog2(UART_DATA_BITS);
    localparam logic [CntW-1:0] CntMax  = CntW'(ClocksPerBaud - 1);
    localparam logic [BitW-1:0] LastBit = BitW'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [BitW-1:0]           bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                      tx_out_q, tx_out_d;
    logic                      tx_busy_q, tx_busy_d;
    logic                      sync1_q, sync1_d;
    logic                      sync2_q, sync2_d;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    logic       cts_ok;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rd_dat;

    assign tx_byte_ready = rst_n && !fifo_full;
    assign cts_ok        = !sync2_q;
    assign tx_out        = tx_out_q;
    assign tx_busy       = tx_busy_q;

    uart_tx_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (tx_byte_valid && tx_byte_ready),
        .push_dat (tx_byte),
        .pop      (fifo_pop),
        .rd_dat   (fifo_rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Frame sequencing, baud count, shifting, and the registered line/busy outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
        sync1_d  = clear_to_send_n;
        sync2_d  = sync1_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        // Line level follows the state already in force, so the output register adds one cycle.
        case (state_q)
            ST_START:  tx_out_d = 1'b0;
            ST_DATA:   tx_out_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_out_d = parity_q;
`endif
            default:   tx_out_d = LINE_IDLE;
        endcase
        tx_busy_d = (state_q != ST_IDLE) || !fifo_empty;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && cts_ok) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rd_dat;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_rd_dat;
`endif
                    cnt_d    = CntMax;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntMax;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntMax;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntMax;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == '0) begin
                    // Chain straight into the next start bit when allowed: no idle gap.
                    if (!fifo_empty && cts_ok) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rd_dat;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_rd_dat;
`endif
                        cnt_d    = CntMax;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any frame in flight and parks the line idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            tx_out_q  <= LINE_IDLE;
            tx_busy_q <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            tx_out_q  <= tx_out_d;
            tx_busy_q <= tx_busy_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_cts_transmitter.sv
// Directed bench for uart_cts_transmitter: frame shape, back-to-back, CTS gating, reset mid-frame.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Frame expectations are built from the byte value: start 0, LSB-first data, optional parity, stop 1.
module tb_uart_cts_transmitter;

    localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_ready;
    logic       clear_to_send_n;
    logic       tx_out;
    logic       tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_cts_transmitter #(
        .ClocksPerBaud (CPB),
        .FifoDepth     (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tx_byte         (tx_byte),
        .tx_byte_valid   (tx_byte_valid),
        .tx_byte_ready   (tx_byte_ready),
        .clear_to_send_n (clear_to_send_n),
        .tx_out          (tx_out),
        .tx_busy         (tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Entered on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        tx_byte       = b;
        tx_byte_valid = 1'b1;
        while (!tx_byte_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("push_ready", 32'(tx_byte_ready), 32'd1);
        @(negedge clk);
        tx_byte_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (tx_out !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(tx_out), 32'd0);
    endtask

    // Entered on the falling edge of the first start-bit cycle; checks every cycle of the frame.
    task automatic expect_frame(input logic [7:0] b, input int raise_cts_at);
        logic [10:0] bits;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (k * CPB + c == raise_cts_at) clear_to_send_n = 1'b1;
                check_val($sformatf("frame_%02h_bit%0d_cyc%0d", b, k, c), 32'(tx_out), 32'(bits[k]));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int hi;
        int lo_busy;
        int lat;

        rst_n           = 1'b0;
        tx_byte         = 8'h11;
        tx_byte_valid   = 1'b1;   // must be ignored while in reset
        clear_to_send_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_tx_out", 32'(tx_out), 32'd1);
        check_val("rst_busy", 32'(tx_busy), 32'd0);
        check_val("rst_ready", 32'(tx_byte_ready), 32'd0);
        tx_byte_valid = 1'b0;
        rst_n         = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", 32'(tx_byte_ready), 32'd1);
        repeat (4) @(negedge clk);
        check_val("no_push_in_rst_busy", 32'(tx_busy), 32'd0);
        check_val("no_push_in_rst_line", 32'(tx_out), 32'd1);

        // 0x55 with CTS asserted: line still high one and two edges after the push edge
        push_byte(8'h55);
        check_val("lat_n0_line", 32'(tx_out), 32'd1);
        @(negedge clk);
        check_val("lat_n1_line", 32'(tx_out), 32'd1);
        check_val("lat_n1_busy", 32'(tx_busy), 32'd1);
        @(negedge clk);
        check_val("lat_n2_start", 32'(tx_out), 32'd0);
        expect_frame(8'h55, -1);
        check_val("busy_after_55", 32'(tx_busy), 32'd0);

        // Fill the FIFO with CTS held off, then release for four contiguous frames
        clear_to_send_n = 1'b1;
        repeat (3) @(negedge clk);
        push_byte(8'h59);
        push_byte(8'h58);
        push_byte(8'h57);
        push_byte(8'h56);
        check_val("full_ready_low", 32'(tx_byte_ready), 32'd0);
        check_val("full_busy", 32'(tx_busy), 32'd1);
        tx_byte       = 8'hEE;   // offered while full, never accepted
        tx_byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_byte_valid   = 1'b0;
        clear_to_send_n = 1'b0;
        wait_start("b2b_start");
        check_val("ready_after_pop", 32'(tx_byte_ready), 32'd1);
        expect_frame(8'h59, -1);
        expect_frame(8'h58, -1);
        expect_frame(8'h57, -1);
        expect_frame(8'h56, -1);
        check_val("busy_after_b2b", 32'(tx_busy), 32'd0);
        check_val("line_after_b2b", 32'(tx_out), 32'd1);

        // CTS held off: byte waits indefinitely
        clear_to_send_n = 1'b1;
        repeat (3) @(negedge clk);
        push_byte(8'hA5);
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx_out === 1'b1) hi++;
            @(negedge clk);
        end
        check_val("cts_hold_high", 32'(hi), 32'd200);
        check_val("cts_hold_busy", 32'(tx_busy), 32'd1);
        // Two synchronizer edges plus the load edge; output register makes it visible one edge later
        clear_to_send_n = 1'b0;
        lat = 0;
        while (tx_out !== 1'b0 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check_val("cts_release_latency", 32'(lat), 32'd4);
        expect_frame(8'hA5, -1);

        // CTS raised mid-DATA: current frame completes, queued byte held
        push_byte(8'h3C);
        push_byte(8'hC3);
        wait_start("cts_mid_start");
        expect_frame(8'h3C, 30);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_out === 1'b1) hi++;
            @(negedge clk);
        end
        check_val("held_c3_high", 32'(hi), 32'd100);
        check_val("held_c3_busy", 32'(tx_busy), 32'd1);
        clear_to_send_n = 1'b0;
        wait_start("c3_start");
        expect_frame(8'hC3, -1);

        // Reset in DATA bit 4 with two bytes queued
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC4);
        wait_start("rst_mid_start");
        repeat (42) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_mid_line", 32'(tx_out), 32'd1);
        check_val("rst_mid_busy", 32'(tx_busy), 32'd0);
        check_val("rst_mid_ready", 32'(tx_byte_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hi      = 0;
        lo_busy = 0;
        for (int i = 0; i < 150; i++) begin
            if (tx_out === 1'b1) hi++;
            if (tx_busy === 1'b0) lo_busy++;
            @(negedge clk);
        end
        check_val("post_rst_quiet_line", 32'(hi), 32'd150);
        check_val("post_rst_quiet_busy", 32'(lo_busy), 32'd150);
        push_byte(8'h81);
        wait_start("post_rst_start");
        expect_frame(8'h81, -1);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones (parity 1); 0x03 has two (parity 0)
        push_byte(8'h07);
        wait_start("par07_start");
        expect_frame(8'h07, -1);
        push_byte(8'h03);
        wait_start("par03_start");
        expect_frame(8'h03, -1);
`endif

        check_val("final_busy", 32'(tx_busy), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
